// File: rtl/bus_dma_master.sv
// bus_dma_master: single-channel word copy engine that is the only master on the system bus.
// It reads one 64-bit word from cur_src, then writes it to cur_dst, and repeats until
// `remaining` reaches zero. The bus registers slave select, so each read is followed by a
// RD_WAIT cycle that captures the returned data. m_req stays high for the whole copy.
module bus_dma_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_reg;
  logic [15:0] cur_src_reg;
  logic [15:0] cur_dst_reg;
  logic [15:0] remaining_reg;
  logic [63:0] data_reg;

  // Incremented addresses wrap naturally at 16 bits.
  logic [15:0] src_next;
  logic [15:0] dst_next;

  assign src_next = cur_src_reg + 16'd1;
  assign dst_next = cur_dst_reg + 16'd1;

  // The captured read word doubles as the write data, so m_dout only moves on entry to WR.
  assign m_dout = data_reg;

  // Copy FSM: next state and every bus/status output are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cur_src_reg   <= 16'd0;
      cur_dst_reg   <= 16'd0;
      remaining_reg <= 16'd0;
      data_reg      <= 64'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_req         <= 1'b0;
      m_wr          <= 1'b0;
      m_addr        <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cur_src_reg   <= src_addr;
            cur_dst_reg   <= dst_addr;
            remaining_reg <= length;
            busy          <= 1'b1;
            if (length == 16'd0) begin
              // Nothing to copy: finish without ever touching the bus.
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= REQ;
              m_req     <= 1'b1;
              m_wr      <= 1'b0;
              m_addr    <= src_addr;
            end
          end
        end

        REQ: begin
          if (m_grant) begin
            state_reg <= RD;
          end
        end

        RD: begin
          // Address phase of the read; hold until the arbiter grants it.
          if (m_grant) begin
            state_reg <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // Data for the address driven in RD arrives now, grant or not.
          data_reg  <= m_din;
          state_reg <= WR;
          m_wr      <= 1'b1;
          m_addr    <= cur_dst_reg;
        end

        WR: begin
          if (m_grant) begin
            cur_src_reg   <= src_next;
            cur_dst_reg   <= dst_next;
            remaining_reg <= remaining_reg - 16'd1;
            if (remaining_reg == 16'd1) begin
              state_reg <= DONE;
              done      <= 1'b1;
              m_req     <= 1'b0;
              m_wr      <= 1'b0;
              m_addr    <= 16'd0;
            end else begin
              // Next word: keep m_req high so there is no request gap.
              state_reg <= RD;
              m_wr      <= 1'b0;
              m_addr    <= src_next;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          m_req     <= 1'b0;
          m_wr      <= 1'b0;
          m_addr    <= 16'd0;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          m_req     <= 1'b0;
          m_wr      <= 1'b0;
          m_addr    <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master: a registered-read bus slave with a 64K-word memory,
// a grant generator (follows m_req one cycle late, with optional random or directed
// drops), and a word-by-word copy model that predicts the write sequence and final memory.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din = 64'd0;

  always #5 clk = ~clk;

  bus_dma_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din)
  );

  logic [63:0] mem     [0:65535];
  logic [63:0] exp_mem [0:65535];
  logic [15:0] wlog_a [$];
  logic [63:0] wlog_d [$];

  logic gnt_q     = 1'b0;
  bit   rand_gnt  = 1'b0;
  bit   dir_arm   = 1'b0;
  int   hold_cnt  = 0;
  int   dir_phase = 0;

  int n_checks = 0;
  int n_pass   = 0;

  assign m_grant = gnt_q && (hold_cnt == 0);

  // Bus slave: grant follows the request one cycle late; reads return data next cycle.
  always @(posedge clk) begin
    gnt_q <= m_req && (!rand_gnt || ($urandom_range(0, 3) != 0));
    if (m_req && m_grant) begin
      if (m_wr) begin
        mem[m_addr] = m_dout;
        wlog_a.push_back(m_addr);
        wlog_d.push_back(m_dout);
      end else begin
        m_din <= mem[m_addr];
      end
    end
  end

  // Directed grant drops: two cycles during the first write, then two during the next read.
  always @(negedge clk) begin
    if (!dir_arm) begin
      hold_cnt  = 0;
      dir_phase = 0;
    end else if (hold_cnt > 0) begin
      hold_cnt = hold_cnt - 1;
    end else if (dir_phase == 0 && m_req && m_wr) begin
      hold_cnt  = 2;
      dir_phase = 1;
    end else if (dir_phase == 1 && m_req && !m_wr) begin
      hold_cnt  = 2;
      dir_phase = 2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // mode: 0 steady grant, 1 random grant, 2 directed grant drops,
  //       3 start pulse while busy, 4 reset during the second write
  task automatic run_copy(input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input int mode);
    logic [15:0] ea [$];
    logic [63:0] ed [$];
    logic [15:0] a;
    logic [63:0] d;
    int  nw, cyc, done_cyc, gaps, bound, diffs, n;
    bit  finished, seen_req, aborted, any_done, any_req;
    finished = 0; seen_req = 0; aborted = 0; any_done = 0; any_req = 0;
    done_cyc = 0; gaps = 0; diffs = 0;

    // Reference: copy word i after word i-1 has landed; an abort keeps only word 0.
    nw = (mode == 4) ? 1 : int'(len);
    for (int i = 0; i < nw; i++) begin
      a = dst + 16'(i);
      d = exp_mem[src + 16'(i)];
      exp_mem[a] = d;
      ea.push_back(a);
      ed.push_back(d);
    end

    rand_gnt = (mode == 1);
    dir_arm  = (mode == 2);
    wlog_a.delete();
    wlog_d.delete();

    src_addr = src; dst_addr = dst; length = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 64'(busy), 64'd1);

    bound = 20 * int'(len) + 50;
    while (!finished && cyc < bound) begin
      if (m_req) seen_req = 1;
      else if (seen_req && !done) gaps++;
      if (done) begin
        finished = 1;
        done_cyc = cyc;
        chk("done_addr", 64'(m_addr), 64'd0);
        chk("done_wr", 64'(m_wr), 64'd0);
      end else if (mode == 4 && m_wr && wlog_a.size() == 1) begin
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_req", 64'(m_req), 64'd0);
        chk("abort_wr", 64'(m_wr), 64'd0);
        chk("abort_addr", 64'(m_addr), 64'd0);
        chk("abort_dout", m_dout, 64'd0);
        aborted  = 1;
        finished = 1;
      end else begin
        if (mode == 3 && cyc == 4) begin
          start = 1'b1;
          src_addr = src ^ 16'h5555;
          dst_addr = dst ^ 16'h0F0F;
          length   = len + 16'd3;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;

    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        if (done) any_done = 1;
        if (m_req) any_req = 1;
      end
      reset_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (done) any_done = 1;
        if (m_req) any_req = 1;
      end
      chk("abort_no_done", 64'(any_done), 64'd0);
      chk("abort_no_req", 64'(any_req), 64'd0);
      chk("abort_idle_busy", 64'(busy), 64'd0);
    end else begin
      chk("done_seen", 64'(finished), 64'd1);
      if (finished) begin
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
      end else begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      if (mode == 0)
        chk("latency", 64'(done_cyc), (len == 16'd0) ? 64'd1 : 64'(3 + 3 * int'(len)));
      chk("req_gaps", 64'(gaps), 64'd0);
      if (len == 16'd0) chk("len0_no_req", 64'(seen_req), 64'd0);
    end

    chk("write_count", 64'(wlog_a.size()), 64'(ea.size()));
    n = (wlog_a.size() < ea.size()) ? wlog_a.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk("write_addr", 64'(wlog_a[i]), 64'(ea[i]));
      chk("write_data", wlog_d[i], ed[i]);
    end
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== exp_mem[i]) diffs++;
    chk("mem_contents", 64'(diffs), 64'd0);

    $display("copy src=%h dst=%h len=%0d mode=%0d done_cycle=%0d writes=%0d",
             src, dst, len, mode, done_cyc, wlog_a.size());
    rand_gnt = 1'b0;
    dir_arm  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] w;
    logic [3:0]  nib;
    reset_n = 1'b0; start = 1'b0;
    src_addr = 16'd0; dst_addr = 16'd0; length = 16'd0;

    for (int i = 0; i < 65536; i++) begin
      w = {$urandom, $urandom};
      mem[i] = w;
      exp_mem[i] = w;
    end
    for (int k = 0; k < 4; k++) begin
      nib = 4'(k + 1);
      w = {16{nib}};
      mem[k] = w;
      exp_mem[k] = w;
    end

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_req", 64'(m_req), 64'd0);
    chk("reset_wr", 64'(m_wr), 64'd0);
    chk("reset_addr", 64'(m_addr), 64'd0);
    chk("reset_dout", m_dout, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_copy(16'h0000, 16'h0100, 16'd4, 0);
    run_copy(16'h0040, 16'h0200, 16'd0, 0);
    run_copy(16'hFFFE, 16'h7FFF, 16'd3, 0);
    run_copy(16'h0010, 16'h0300, 16'd4, 2);
    run_copy(16'h0020, 16'h0400, 16'd4, 3);
    run_copy(16'h0030, 16'h0500, 16'd4, 4);
    run_copy(16'h0030, 16'h0500, 16'd4, 0);

    for (int t = 0; t < 12; t++)
      run_copy(16'($urandom), 16'($urandom), 16'($urandom_range(0, 12)),
               int'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
